serial_adder: RTL

- Bit-serial WIDTH-bit adder built around a half-adder sum/carry datapath.
- Per cycle it consumes one operand bit pair plus the registered carry, and produces one sum bit.
- Two cascaded half-adder stages form the full-add; the carry is registered between bits.
- Used where area matters more than latency; a start/ready/done handshake sequences each operation.

---
 rtl/serial_adder.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per cycle through two cascaded
// half-adder stages, with the carry registered between bits and a start/ready/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic ha0_s;
    logic ha0_c;
    logic ha1_s;
    logic ha1_c;
    logic carry_next;
    logic last_bit;
    logic accept;

    // Full add built from two half adders: (a^b, a&b) then (p^carry, p&carry).
    assign ha0_s      = a_sr[0] ^ b_sr[0];
    assign ha0_c      = a_sr[0] & b_sr[0];
    assign ha1_s      = ha0_s ^ carry;
    assign ha1_c      = ha0_s & carry;
    assign carry_next = ha0_c | ha1_c;

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = ha1_s;
        end else begin : g_res_wn
            assign res_next = {ha1_s, res_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign ready    = (state == IDLE) || (state == DONE);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);
    assign accept   = ready && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= carry_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        state <= DONE;
                        sum   <= res_next;
                        cout  <= carry_next;
                    end
                end
                IDLE, DONE: begin
                    // DONE accepts a new start directly so back-to-back operations have no gap.
                    if (accept) begin
                        state <= SHIFT;
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
